// File: rtl/note_display_if.sv
// note_display_if: frame-rate handshake between the VGA-side control inputs
// (frame pulse, detected notes, mode) and the display controller outputs.
interface note_display_if;
   logic       frame_start;
   logic [7:0] note_array;
   logic       mode;
   logic [7:0] highlight;
   logic [7:0] cursor;
   logic       mode_q;
   logic       hit;
   logic [7:0] score;

   // Driver of the sampled inputs, consumer of the display outputs.
   modport master (
      output frame_start, note_array, mode,
      input  highlight, cursor, mode_q, hit, score
   );

   // The display controller itself.
   modport slave (
      input  frame_start, note_array, mode,
      output highlight, cursor, mode_q, hit, score
   );
endinterface

// File: rtl/note_display_ctrl.sv
// note_display_ctrl: frame-synchronous note highlighting plus a play-mode
// cursor that walks the 8 notes and reports whether each target was played.
// All display state moves only on frame_start so the picture never tears.
// Optional feature macro: NOTE_SCORE_EN -- when defined, a saturating
// per-session hit score is kept; otherwise score is tied to zero.
module note_display_ctrl #(
   parameter int HOLD_FRAMES = 6,   // frames a highlight lingers after release (1..15)
   parameter int STEP_FRAMES = 30   // frames per play-mode cursor step (2..255)
) (
   input  logic          clk,
   input  logic          reset,     // synchronous, active-low
   note_display_if.slave bus
);

   typedef enum logic [1:0] {
      LISTEN = 2'd0,
      ARM    = 2'd1,
      PLAY   = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_FRAMES);
   localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

   // ------------------------------------------------------------------
   // Highlight hold counters
   // ------------------------------------------------------------------
   logic [7:0][3:0] hold_reg;
   logic [7:0][3:0] hold_next;
   logic [7:0]      highlight_reg;
   logic [7:0]      highlight_next;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_hold
         // Reload on a sounding note, otherwise decay toward zero, one step per frame.
         assign hold_next[gi] = !bus.frame_start        ? hold_reg[gi] :
                                bus.note_array[gi]      ? HOLD_LOAD    :
                                (hold_reg[gi] != 4'd0)  ? hold_reg[gi] - 4'd1 :
                                                          4'd0;
         // Highlight follows the post-update counter so it moves on the frame edge itself.
         assign highlight_next[gi] = (hold_next[gi] != 4'd0);
      end
   endgenerate

   // Hold counters and highlight mask register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_reg      <= '0;
         highlight_reg <= 8'h00;
      end else begin
         hold_reg      <= hold_next;
         highlight_reg <= highlight_next;
      end
   end

   // ------------------------------------------------------------------
   // Play-mode FSM
   // ------------------------------------------------------------------
   state_t     state_reg, state_next;
   logic [7:0] cursor_reg, cursor_next;
   logic [7:0] step_cnt_reg, step_cnt_next;
   logic       hit_seen_reg, hit_seen_next;
   logic       hit_reg, hit_next;
   logic       mode_q_reg, mode_q_next;
   logic       target_played;

   assign target_played = |(bus.note_array & cursor_reg);

   // FSM state and play bookkeeping registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= LISTEN;
         cursor_reg   <= 8'h00;
         step_cnt_reg <= 8'd0;
         hit_seen_reg <= 1'b0;
         hit_reg      <= 1'b0;
         mode_q_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cursor_reg   <= cursor_next;
         step_cnt_reg <= step_cnt_next;
         hit_seen_reg <= hit_seen_next;
         hit_reg      <= hit_next;
         mode_q_reg   <= mode_q_next;
      end
   end

   // Next-state and step evaluation; nothing moves except on frame_start,
   // and hit defaults low so it can never stretch past one cycle.
   always_comb begin
      state_next    = state_reg;
      cursor_next   = cursor_reg;
      step_cnt_next = step_cnt_reg;
      hit_seen_next = hit_seen_reg;
      hit_next      = 1'b0;
      mode_q_next   = mode_q_reg;

      if (bus.frame_start) begin
         mode_q_next = bus.mode;
         case (state_reg)
            LISTEN: begin
               if (bus.mode) begin
                  state_next    = ARM;
                  cursor_next   = 8'h01;
                  step_cnt_next = 8'd0;
                  hit_seen_next = 1'b0;
               end
            end
            ARM: begin
               // One alignment frame so the first step starts on a clean frame.
               if (!bus.mode) begin
                  state_next    = LISTEN;
                  cursor_next   = 8'h00;
                  step_cnt_next = 8'd0;
                  hit_seen_next = 1'b0;
               end else begin
                  state_next    = PLAY;
               end
            end
            PLAY: begin
               if (!bus.mode) begin
                  // Leaving abandons the step in progress without scoring it.
                  state_next    = LISTEN;
                  cursor_next   = 8'h00;
                  step_cnt_next = 8'd0;
                  hit_seen_next = 1'b0;
               end else if (step_cnt_reg >= STEP_LAST) begin
                  // Last frame of the step counts as a chance to play the target too.
                  hit_next      = hit_seen_reg | target_played;
                  cursor_next   = {cursor_reg[6:0], cursor_reg[7]};
                  step_cnt_next = 8'd0;
                  hit_seen_next = 1'b0;
               end else begin
                  step_cnt_next = step_cnt_reg + 8'd1;
                  hit_seen_next = hit_seen_reg | target_played;
               end
            end
            default: begin
               state_next    = LISTEN;
               cursor_next   = 8'h00;
               step_cnt_next = 8'd0;
               hit_seen_next = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Session score
   // ------------------------------------------------------------------
`ifdef NOTE_SCORE_EN
   logic [7:0] score_reg;
   logic       score_clear;

   // A new session starts exactly when LISTEN accepts mode=1.
   assign score_clear = bus.frame_start && (state_reg == LISTEN) && bus.mode;

   // Score counts hits on the same edge the hit pulse is raised, saturating at 255.
   always_ff @(posedge clk) begin
      if (!reset) begin
         score_reg <= 8'h00;
      end else if (score_clear) begin
         score_reg <= 8'h00;
      end else if (hit_next && (score_reg != 8'hFF)) begin
         score_reg <= score_reg + 8'd1;
      end
   end

   assign bus.score = score_reg;
`else
   assign bus.score = 8'h00;
`endif

   assign bus.highlight = highlight_reg;
   assign bus.cursor    = cursor_reg;
   assign bus.mode_q    = mode_q_reg;
   assign bus.hit       = hit_reg;

endmodule

// File: doc/note_display_ctrl.md
NOTE_DISPLAY_CTRL -- requirements
Module: note_display_ctrl

Interface
REQ-001 Parameter HOLD_FRAMES, default 6, frames a note highlight persists after release (legal 1..15).
REQ-002 Parameter STEP_FRAMES, default 30, frames per play-mode cursor step (legal 2..255).
REQ-003 clk  input  1  system clock; the same clock as the VGA sync circuit.
REQ-004 reset  input  1  synchronous reset, active-low.
REQ-005 frame_start  input  1  one-cycle pulse at the start of each vertical blank, from the VGA sync circuit.
REQ-006 note_array  input  8  live detected-note vector; bit i set means note i is sounding.
REQ-007 mode  input  1  0 = listen mode, 1 = play mode.
REQ-008 highlight  output  8  per-note highlight mask for the graphics generator.
REQ-009 cursor  output  8  one-hot play-mode target note; 8'h00 in listen mode.
REQ-010 mode_q  output  1  frame-aligned copy of mode.
REQ-011 hit  output  1  one-cycle pulse when a play-mode step ends with its target note played.
REQ-012 score  output  8  count of hits in the current play session.

Function
REQ-013 Inputs note_array and mode shall be sampled only on cycles where frame_start=1; all other cycles shall leave display state unchanged (tear-free update).
REQ-014 Each of 8 hold counters (4 bits) shall, at frame_start, load HOLD_FRAMES if its sampled note bit=1, else decrement if nonzero, else hold 0.
REQ-015 highlight[i] shall be registered as (hold counter i != 0) and shall change exactly 1 cycle after the frame_start that caused the change.
REQ-016 The FSM states shall be LISTEN, ARM and PLAY; the reset state is LISTEN.
REQ-017 LISTEN: at frame_start with sampled mode=1 -> ARM; cursor<=8'h01, step_cnt<=0, hit_seen<=0, score<=0.
REQ-018 ARM: the next frame_start -> PLAY (one alignment frame; no step counting and no hit_seen update in ARM).
REQ-019 PLAY: at frame_start with (sampled note_array & cursor)!=0, hit_seen shall be set.
REQ-020 PLAY: at frame_start with step_cnt<STEP_FRAMES-1, step_cnt shall increment.
REQ-021 PLAY: at frame_start with step_cnt==STEP_FRAMES-1, hit shall pulse on the next cycle iff (hit_seen OR the current sample matches the cursor); cursor shall rotate left (8'h80 wraps to 8'h01); step_cnt<=0; hit_seen<=0.
REQ-022 On a hit, score shall increment and saturate at 255.
REQ-023 ARM or PLAY: at frame_start with sampled mode=0 -> LISTEN; cursor<=8'h00, hit=0, with no step evaluation on that frame; score shall hold its final value.
REQ-024 mode_q shall update 1 cycle after each frame_start with the sampled mode.
REQ-025 hit shall never exceed 1 cycle in width and shall be 0 in LISTEN and ARM.
REQ-026 Back-to-back frame_start on consecutive cycles shall each be processed as a full frame.

Reset
REQ-027 With reset=0 on a rising clk edge: state=LISTEN; highlight, cursor and score=8'h00; hold counters, step_cnt, hit_seen, hit and mode_q=0.
REQ-028 Reset shall take priority over frame_start in the same cycle, including a reset asserted mid-step in PLAY.

Configuration
REQ-029 With macro NOTE_SCORE_EN defined, score shall behave per REQ-017/REQ-022/REQ-023.
REQ-030 Without NOTE_SCORE_EN, score shall be tied to 8'h00 with no score register; hit shall be unaffected.

Verification
REQ-031 Reset then note_array=8'h04 across one frame_start -> highlight=8'h04 one cycle later; note released -> highlight bit stays set for 6 frames and clears at the 6th frame_start after release.
REQ-032 note_array toggles between frame_start pulses -> highlight unchanged until the next frame_start.
REQ-033 mode=1 at frame_start -> cursor=8'h01, state ARM; with STEP_FRAMES=30 and note_array=8'h01 held, first hit pulse 31 frames after entry; cursor=8'h02; score=1.
REQ-034 Play 8 steps with no notes -> hit never asserted; cursor sequence 01,02,...,80,01; score=0.
REQ-035 Force score=255 via 255 hits, then one more hit -> score stays 255; mode=0 -> cursor=8'h00, score holds 255; re-enter play -> score=0.
REQ-036 reset=0 asserted mid-step in PLAY with frame_start high in the same cycle -> all outputs 0 on the next cycle; NOTE_SCORE_EN undefined build -> score constantly 0 through REQ-033.
